// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud timing helpers.
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Rounded system-clock cycles per oversampling tick.
    function automatic int tick_div(
        input longint freq,
        input longint baud,
        input longint os
    );
        longint den;
        den = baud * os;
        return int'((freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Divisor counter producing a one-cycle tick every p_div cycles.
module uart_tick_gen #(
    parameter int p_div = 27
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (p_div > 1) ? $clog2(p_div) : 1;
    localparam logic [CW-1:0] LAST = CW'(p_div - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (i_clr || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_tick = (cnt_q == LAST) && !i_clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with oversampled bit timing and valid/ready byte output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int p_input_freq = 50_000_000,
    parameter int p_baud       = 115_200,
    parameter int p_oversample = DEFAULT_OVERSAMPLE,
    parameter int p_data_bits  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    output logic [p_data_bits-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_frame_err,
    output logic                   o_overrun
);

    localparam int DIV = tick_div(p_input_freq, p_baud, p_oversample);
    localparam int TW  = $clog2(p_oversample);
    localparam int BW  = (p_data_bits > 1) ? $clog2(p_data_bits) : 1;

    localparam logic [TW-1:0] T_HALF = TW'(p_oversample / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(p_oversample - 1);
    localparam logic [BW-1:0] B_LAST = BW'(p_data_bits - 1);

    logic       rx_meta_q;
    logic       rx_s_q;
    logic       rx_hi_q;
    logic [1:0] fill_q;
    logic       fall;

    rx_state_e              state_q, state_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [p_data_bits-1:0] shift_q, shift_d;
    logic                   brk_q, brk_d;

    logic tick;
    logic tick_clr;
    logic byte_done;
    logic stop_bad;

    // fill_q marks when the synchronizer holds real line samples rather
    // than its reset value, so a line held low since reset is no edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            fill_q    <= 2'b00;
            rx_hi_q   <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            fill_q    <= {fill_q[0], 1'b1};
            rx_hi_q   <= fill_q[1] & rx_s_q;
        end
    end

    assign fall = rx_hi_q & ~rx_s_q;

    uart_tick_gen #(
        .p_div(DIV)
    ) u_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (tick_clr),
        .o_tick(tick)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        brk_d     = brk_q;
        tick_clr  = 1'b0;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    tick_clr = 1'b1;
                    tcnt_d   = '0;
                    bcnt_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt_q == T_HALF) begin
                        tcnt_d  = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s_q, shift_q[p_data_bits-1:1]};
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == B_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                // After a bad stop bit, hold here until the line recovers
                // so a break cannot start a new frame.
                if (brk_q) begin
                    if (rx_s_q) begin
                        brk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d = '0;
                        if (rx_s_q) begin
                            byte_done = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            stop_bad = 1'b1;
                            brk_d    = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= stop_bad;
            o_overrun   <= byte_done & o_valid & ~i_ready;
            if (byte_done && (!o_valid || i_ready)) begin
                o_data  <= shift_q;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
